unidade_acesso_memoria: RTL and testbench

- MEM-stage initiator for the data memory block. Accepts one load/store request at a time from the EX/MEM pipeline register.
- Translates each request into word-indexed memory cycles using the memory's convention: controle=0 writes, controle=1 reads.
- Performs sub-word loads with sign/zero extension and sub-word stores via read-modify-write.
- Returns load data to the WB path with a valid/ready-style handshake.

---
 rtl/pipeline_pkg.sv | 34 +++
 rtl/alinhador_dados.sv | 67 ++++++
 rtl/unidade_acesso_memoria.sv | 145 ++++++++++++++
 tb/tb_unidade_acesso_memoria.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared encodings for the MEM-stage memory access unit: request sizes,
// memory control polarity, FSM states and the alignment rule.
package pipeline_pkg;

  localparam logic [1:0] TAM_BYTE   = 2'b00;
  localparam logic [1:0] TAM_HALF   = 2'b01;
  localparam logic [1:0] TAM_WORD   = 2'b10;
  localparam logic [1:0] TAM_ILEGAL = 2'b11;

  // The data memory writes when controle is low and reads when it is high.
  localparam logic MEM_ESCREVE = 1'b0;
  localparam logic MEM_LE      = 1'b1;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    LEITURA  = 2'd1,
    ESCRITA  = 2'd2,
    RESPOSTA = 2'd3
  } estado_t;

  // True when the size is illegal or the byte offset breaks natural alignment.
  function automatic logic acesso_invalido(input logic [1:0] tamanho,
                                           input logic [1:0] deslocamento);
    logic invalido;
    case (tamanho)
      TAM_BYTE: invalido = 1'b0;
      TAM_HALF: invalido = deslocamento[0];
      TAM_WORD: invalido = (deslocamento != 2'b00);
      default:  invalido = 1'b1;
    endcase
    return invalido;
  endfunction

endpackage

// File: rtl/alinhador_dados.sv
// Combinational lane handling for 32-bit little-endian words: extracts and
// extends a load lane, and merges store data into a read word for RMW.
module alinhador_dados
  import pipeline_pkg::*;
(
  input  logic [31:0] palavra,
  input  logic [1:0]  tamanho,
  input  logic [1:0]  deslocamento,
  input  logic        sinal,
  input  logic [31:0] dado,
  output logic [31:0] carga,
  output logic [31:0] mescla
);

  logic [7:0]  byte_s;
  logic [15:0] meia_s;

  // Select the addressed lane and extend it for the load path.
  always_comb begin
    byte_s = 8'h00;
    meia_s = 16'h0000;
    case (deslocamento)
      2'b00:   byte_s = palavra[7:0];
      2'b01:   byte_s = palavra[15:8];
      2'b10:   byte_s = palavra[23:16];
      2'b11:   byte_s = palavra[31:24];
      default: byte_s = 8'h00;
    endcase
    if (deslocamento[1]) begin
      meia_s = palavra[31:16];
    end else begin
      meia_s = palavra[15:0];
    end
    case (tamanho)
      TAM_BYTE: carga = sinal ? {{24{byte_s[7]}}, byte_s} : {24'h000000, byte_s};
      TAM_HALF: carga = sinal ? {{16{meia_s[15]}}, meia_s} : {16'h0000, meia_s};
      TAM_WORD: carga = palavra;
      default:  carga = 32'h0000_0000;
    endcase
  end

  // Replace only the addressed lane with the low bits of the store data.
  always_comb begin
    mescla = palavra;
    case (tamanho)
      TAM_BYTE: begin
        case (deslocamento)
          2'b00:   mescla[7:0]   = dado[7:0];
          2'b01:   mescla[15:8]  = dado[7:0];
          2'b10:   mescla[23:16] = dado[7:0];
          2'b11:   mescla[31:24] = dado[7:0];
          default: mescla        = palavra;
        endcase
      end
      TAM_HALF: begin
        if (deslocamento[1]) begin
          mescla[31:16] = dado[15:0];
        end else begin
          mescla[15:0] = dado[15:0];
        end
      end
      TAM_WORD: mescla = dado;
      default:  mescla = palavra;
    endcase
  end

endmodule

// File: rtl/unidade_acesso_memoria.sv
// MEM-stage initiator: one load/store at a time, word-indexed memory cycles,
// sub-word loads with extension and sub-word stores by read-modify-write.
module unidade_acesso_memoria
  import pipeline_pkg::*;
#(
  parameter int LARGURA     = 32,
  parameter int LAT_LEITURA = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valido,
  output logic               req_pronto,
  input  logic               req_escrita,
  input  logic [1:0]         req_tamanho,
  input  logic               req_sinal,
  input  logic [LARGURA-1:0] req_endereco,
  input  logic [LARGURA-1:0] req_dado,
  output logic               resp_valido,
  output logic [LARGURA-1:0] resp_dado,
  output logic               resp_erro,
  output logic [LARGURA-1:0] mem_endereco,
  output logic [LARGURA-1:0] mem_valor,
  output logic               mem_controle,
  input  logic [LARGURA-1:0] mem_saida
);

  // mem_saida is sampled at the end of the last LEITURA cycle.
  localparam logic [2:0] ULTIMO_CICLO = 3'(LAT_LEITURA - 1);

  estado_t            estado_r, prox_estado_s;
  logic [2:0]         contador_r, prox_contador_s;
  logic               escrita_r, prox_escrita_s;
  logic [1:0]         tamanho_r, prox_tamanho_s;
  logic               sinal_r, prox_sinal_s;
  logic [1:0]         deslocamento_r, prox_deslocamento_s;
  logic [LARGURA-1:0] dado_r, prox_dado_s;
  logic               prox_req_pronto_s, prox_resp_valido_s, prox_resp_erro_s;
  logic               prox_mem_controle_s;
  logic [LARGURA-1:0] prox_resp_dado_s, prox_mem_endereco_s, prox_mem_valor_s;
  logic [LARGURA-1:0] carga_s, mescla_s;

  alinhador_dados u_alinhador (
    .palavra      (mem_saida),
    .tamanho      (tamanho_r),
    .deslocamento (deslocamento_r),
    .sinal        (sinal_r),
    .dado         (dado_r),
    .carga        (carga_s),
    .mescla       (mescla_s)
  );

  // State, captured request and all outputs are registered together.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r       <= OCIOSO;
      contador_r     <= 3'd0;
      escrita_r      <= 1'b0;
      tamanho_r      <= TAM_BYTE;
      sinal_r        <= 1'b0;
      deslocamento_r <= 2'b00;
      dado_r         <= {LARGURA{1'b0}};
      req_pronto     <= 1'b1;
      resp_valido    <= 1'b0;
      resp_dado      <= {LARGURA{1'b0}};
      resp_erro      <= 1'b0;
      mem_endereco   <= {LARGURA{1'b0}};
      mem_valor      <= {LARGURA{1'b0}};
      mem_controle   <= MEM_LE;
    end else begin
      estado_r       <= prox_estado_s;
      contador_r     <= prox_contador_s;
      escrita_r      <= prox_escrita_s;
      tamanho_r      <= prox_tamanho_s;
      sinal_r        <= prox_sinal_s;
      deslocamento_r <= prox_deslocamento_s;
      dado_r         <= prox_dado_s;
      req_pronto     <= prox_req_pronto_s;
      resp_valido    <= prox_resp_valido_s;
      resp_dado      <= prox_resp_dado_s;
      resp_erro      <= prox_resp_erro_s;
      mem_endereco   <= prox_mem_endereco_s;
      mem_valor      <= prox_mem_valor_s;
      mem_controle   <= prox_mem_controle_s;
    end
  end

  // Next state and next output values; outputs follow the state being entered.
  always_comb begin
    prox_estado_s       = estado_r;
    prox_contador_s     = contador_r;
    prox_escrita_s      = escrita_r;
    prox_tamanho_s      = tamanho_r;
    prox_sinal_s        = sinal_r;
    prox_deslocamento_s = deslocamento_r;
    prox_dado_s         = dado_r;
    prox_mem_endereco_s = mem_endereco;
    prox_mem_valor_s    = mem_valor;
    prox_resp_dado_s    = {LARGURA{1'b0}};
    prox_resp_erro_s    = 1'b0;
    case (estado_r)
      OCIOSO: begin
        if (req_valido && req_pronto) begin
          prox_escrita_s      = req_escrita;
          prox_tamanho_s      = req_tamanho;
          prox_sinal_s        = req_sinal;
          prox_deslocamento_s = req_endereco[1:0];
          prox_dado_s         = req_dado;
          prox_mem_endereco_s = req_endereco >> 2;
          prox_contador_s     = 3'd0;
          if (acesso_invalido(req_tamanho, req_endereco[1:0])) begin
            prox_estado_s    = RESPOSTA;
            prox_resp_erro_s = 1'b1;
          end else if (req_escrita && (req_tamanho == TAM_WORD)) begin
            prox_estado_s    = ESCRITA;
            prox_mem_valor_s = req_dado;
          end else begin
            prox_estado_s = LEITURA;
          end
        end else begin
          prox_estado_s = OCIOSO;
        end
      end
      LEITURA: begin
        if (contador_r == ULTIMO_CICLO) begin
          if (escrita_r) begin
            prox_estado_s    = ESCRITA;
            prox_mem_valor_s = mescla_s;
          end else begin
            prox_estado_s    = RESPOSTA;
            prox_resp_dado_s = carga_s;
          end
        end else begin
          prox_contador_s = contador_r + 3'd1;
        end
      end
      ESCRITA:  prox_estado_s = RESPOSTA;
      RESPOSTA: prox_estado_s = OCIOSO;
      default:  prox_estado_s = OCIOSO;
    endcase
    prox_req_pronto_s   = (prox_estado_s == OCIOSO);
    prox_resp_valido_s  = (prox_estado_s == RESPOSTA);
    prox_mem_controle_s = (prox_estado_s == ESCRITA) ? MEM_ESCREVE : MEM_LE;
  end

endmodule

// File: tb/tb_unidade_acesso_memoria.sv
// Scoreboard bench for unidade_acesso_memoria with a combinational-read
// data memory model (LAT_LEITURA=1).
module tb_unidade_acesso_memoria;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        carregar = 1'b1;
  logic        req_valido = 1'b0;
  logic        req_pronto;
  logic        req_escrita = 1'b0;
  logic [1:0]  req_tamanho = 2'b00;
  logic        req_sinal = 1'b0;
  logic [31:0] req_endereco = 32'h0;
  logic [31:0] req_dado = 32'h0;
  logic        resp_valido;
  logic [31:0] resp_dado;
  logic        resp_erro;
  logic [31:0] mem_endereco;
  logic [31:0] mem_valor;
  logic        mem_controle;
  logic [31:0] mem_saida;

  unidade_acesso_memoria #(.LARGURA(32), .LAT_LEITURA(1)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valido   (req_valido),
    .req_pronto   (req_pronto),
    .req_escrita  (req_escrita),
    .req_tamanho  (req_tamanho),
    .req_sinal    (req_sinal),
    .req_endereco (req_endereco),
    .req_dado     (req_dado),
    .resp_valido  (resp_valido),
    .resp_dado    (resp_dado),
    .resp_erro    (resp_erro),
    .mem_endereco (mem_endereco),
    .mem_valor    (mem_valor),
    .mem_controle (mem_controle),
    .mem_saida    (mem_saida)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] dado;
    logic        erro;
    int          lat;
    int          aceite;
  } esperado_t;

  esperado_t   fila[$];
  esperado_t   atual;
  int          total = 0;
  int          bad = 0;
  int          ciclo = 0;
  int          escritas = 0;
  logic [31:0] ultimo_valor = 32'h0;
  logic [31:0] bloco [0:15];

  always @(posedge clock) ciclo <= ciclo + 1;

  // Memory model: preset while carregar, write on controle=0, read combinationally.
  always @(posedge clock) begin
    if (carregar) begin
      for (int i = 0; i < 16; i++) bloco[i] <= 32'h0;
      bloco[2] <= 32'h1122_3344;
      bloco[3] <= 32'hCAFE_F00D;
      bloco[4] <= 32'h0000_0004;
      bloco[6] <= 32'h6666_6666;
    end else if (mem_controle == 1'b0) begin
      bloco[mem_endereco[3:0]] <= mem_valor;
      escritas     <= escritas + 1;
      ultimo_valor <= mem_valor;
    end
  end
  assign mem_saida = bloco[mem_endereco[3:0]];

  task automatic checar(input string nome, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nome, got, exp);
    end
  endtask

  // Monitor: every response is matched against the oldest expectation.
  always @(negedge clock) begin
    if (resp_valido === 1'b1) begin
      if (fila.size() == 0) begin
        checar("unexpected_resp", {31'd0, resp_valido}, 32'd0);
      end else begin
        atual = fila.pop_front();
        checar("resp_dado", resp_dado, atual.dado);
        checar("resp_erro", {31'd0, resp_erro}, {31'd0, atual.erro});
        checar("latencia", 32'(ciclo - atual.aceite), 32'(atual.lat));
      end
    end
  end

  task automatic checar_reset();
    checar("rst_pronto", {31'd0, req_pronto}, 32'd1);
    checar("rst_resp_valido", {31'd0, resp_valido}, 32'd0);
    checar("rst_resp_dado", resp_dado, 32'd0);
    checar("rst_resp_erro", {31'd0, resp_erro}, 32'd0);
    checar("rst_mem_endereco", mem_endereco, 32'd0);
    checar("rst_mem_valor", mem_valor, 32'd0);
    checar("rst_mem_controle", {31'd0, mem_controle}, 32'd1);
  endtask

  // Called at a negedge; holds the request until accepted, leaves req_valido high.
  task automatic emitir(input logic esc, input logic [1:0] tam, input logic sin,
                        input logic [31:0] ender, input logic [31:0] dado,
                        input logic [31:0] exp_dado, input logic exp_erro,
                        input int exp_lat, input bit empurrar, output int aceite);
    esperado_t e;
    int espera = 0;
    while (req_pronto !== 1'b1 && espera < 50) begin
      @(negedge clock);
      espera++;
    end
    if (espera >= 50) checar("pronto_timeout", {31'd0, req_pronto}, 32'd1);
    req_escrita  = esc;
    req_tamanho  = tam;
    req_sinal    = sin;
    req_endereco = ender;
    req_dado     = dado;
    req_valido   = 1'b1;
    aceite       = ciclo;
    if (empurrar) begin
      e.dado = exp_dado; e.erro = exp_erro; e.lat = exp_lat; e.aceite = ciclo;
      fila.push_back(e);
    end
    @(negedge clock);
  endtask

  task automatic concluir();
    int espera = 0;
    req_valido = 1'b0;
    while ((fila.size() != 0 || req_pronto !== 1'b1) && espera < 50) begin
      @(negedge clock);
      espera++;
    end
    if (espera >= 50) checar("resp_timeout", 32'(fila.size()), 32'd0);
    @(negedge clock);
  endtask

  initial begin
    int a1, a2, w0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    carregar = 1'b0;
    @(negedge clock);
    checar_reset();

    // Word load from 0x10: word index 4, read only.
    w0 = escritas;
    emitir(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0000_0004, 1'b0, 2, 1'b1, a1);
    checar("load_mem_endereco", mem_endereco, 32'd4);
    checar("load_mem_controle", {31'd0, mem_controle}, 32'd1);
    checar("load_pronto_baixo", {31'd0, req_pronto}, 32'd0);
    concluir();
    checar("load_sem_escrita", 32'(escritas - w0), 32'd0);

    // Byte store 0xAB to 0x09 over 0x11223344 (RMW).
    w0 = escritas;
    emitir(1'b1, 2'b00, 1'b0, 32'h09, 32'h0000_00AB, 32'h0, 1'b0, 3, 1'b1, a1);
    concluir();
    checar("sb_uma_escrita", 32'(escritas - w0), 32'd1);
    checar("sb_mem_valor", ultimo_valor, 32'h1122_AB44);

    // Word store 0x80FF1234 to 0x08.
    w0 = escritas;
    emitir(1'b1, 2'b10, 1'b0, 32'h08, 32'h80FF_1234, 32'h0, 1'b0, 2, 1'b1, a1);
    concluir();
    checar("sw_uma_escrita", 32'(escritas - w0), 32'd1);
    checar("sw_mem_valor", ultimo_valor, 32'h80FF_1234);

    // Byte and half loads, signed and unsigned.
    emitir(1'b0, 2'b00, 1'b1, 32'h0B, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 1'b1, a1);
    concluir();
    emitir(1'b0, 2'b00, 1'b0, 32'h0B, 32'h0, 32'h0000_0080, 1'b0, 2, 1'b1, a1);
    concluir();
    emitir(1'b0, 2'b01, 1'b1, 32'h0A, 32'h0, 32'hFFFF_80FF, 1'b0, 2, 1'b1, a1);
    concluir();
    emitir(1'b0, 2'b01, 1'b0, 32'h08, 32'h0, 32'h0000_1234, 1'b0, 2, 1'b1, a1);
    concluir();

    // Half store to upper lane of word 3, then read the word back.
    emitir(1'b1, 2'b01, 1'b0, 32'h0E, 32'h1234_BEEF, 32'h0, 1'b0, 3, 1'b1, a1);
    concluir();
    emitir(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'hBEEF_F00D, 1'b0, 2, 1'b1, a1);
    concluir();

    // Errors: misaligned word, misaligned half store, illegal size.
    w0 = escritas;
    emitir(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 1, 1'b1, a1);
    concluir();
    emitir(1'b1, 2'b01, 1'b0, 32'h05, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 1'b1, a1);
    concluir();
    emitir(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 1, 1'b1, a1);
    concluir();
    checar("erro_sem_escrita", 32'(escritas - w0), 32'd0);

    // req_valido held high across two stores.
    emitir(1'b1, 2'b10, 1'b0, 32'h14, 32'h1111_1111, 32'h0, 1'b0, 2, 1'b1, a1);
    checar("held_pronto_1", {31'd0, req_pronto}, 32'd0);
    @(negedge clock);
    checar("held_pronto_2", {31'd0, req_pronto}, 32'd0);
    emitir(1'b1, 2'b00, 1'b0, 32'h15, 32'h9999_9922, 32'h0, 1'b0, 3, 1'b1, a2);
    checar("held_intervalo", 32'(a2 - a1), 32'd3);
    concluir();
    emitir(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h1111_2211, 1'b0, 2, 1'b1, a1);
    concluir();

    // Reset during LEITURA of a half store: request dropped, no write.
    w0 = escritas;
    emitir(1'b1, 2'b01, 1'b0, 32'h1A, 32'h0000_AAAA, 32'h0, 1'b0, 3, 1'b0, a1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    req_valido = 1'b0;
    checar_reset();
    repeat (4) @(negedge clock);
    checar("rst_sem_escrita", 32'(escritas - w0), 32'd0);
    emitir(1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 32'h6666_6666, 1'b0, 2, 1'b1, a1);
    concluir();

    checar("fila_vazia", 32'(fila.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
